game_event_ctrl: RTL and testbench
==================================

// Module: game_event_ctrl
// PURPOSE
// - Parametrised successor of the single-collision game controller.
// - Merges Ball drawing request with NUM_OBJ object layers; emits combinational collision, per-layer hit mask, one hit pulse per frame.
// - Accumulates per-frame tile events (gift/hole); commits them at each startOfFrame.
// - Runs game FSM: lives, gift goal, respawn holdoff, latched endgame/victory. Sits between VGA object muxes and top-level game logic.
// PARAMETERS
// - NUM_OBJ      4   collidable object layers (bit0 tiles, bit1 border, ...)
// - LIVES        3   lives loaded at game start, >=1
// - GIFT_GOAL    5   committed gifts required for victory, >=1
// - HOLDOFF_FRM  30  frames in HIT state (hole events ignored)
// PORTS
// - clk                 in   1        system clock
// - resetN              in   1        async active-low reset
// - startOfFrame        in   1        1-clk pulse per frame
// - start_game          in   1        level; starts/restarts a game
// - drawing_request_Ball in  1        ball pixel active
// - drawing_request_Obj in   NUM_OBJ  object layer pixel active
// - TileType            in   2        00 bkg, 01 floor, 10 gift, 11 hole (valid with bit0)
// - collision           out  1        comb: Ball & |drawing_request_Obj
// - hit_mask            out  NUM_OBJ  layers hit since last startOfFrame (sticky)
// - SingleHitPulse      out  1        1-clk pulse, first collision of a frame
// - lives               out  $clog2(LIVES+1)      remaining lives
// - gifts               out  $clog2(GIFT_GOAL+1)  committed gifts
// - score               out  16       see CONFIGURATION
// - game_state          out  3        IDLE=0 PLAY=1 HIT=2 LOST=3 WON=4
// - endgame, victory    out  1        registered, held while LOST/WON (victory WON only)
// BEHAVIOUR
// - Reset: state IDLE, lives=LIVES, gifts=0, score=0, hit_mask=0, flags=0, SingleHitPulse/endgame/victory=0.
// - Clocked control registered; collision only combinational output.
// - Frame semaphore: cleared on startOfFrame; first collision cycle sets it and SingleHitPulse=1 next clk.
// - startOfFrame and collision same cycle: collision belongs to new frame.
// - hit_mask |= request bits on collision; cleared on startOfFrame (same-cycle collision loads fresh value).
// - Event flags hole_seen/gift_seen set on collision with Obj[0] and TileType 11/10 respectively.
// - Commit at startOfFrame from flags (1-frame latency), then flags cleared. At most one hole and one gift per frame.
// - PLAY: hole -> lives-1; lives reaches 0 -> LOST, else HIT, holdoff cnt=HOLDOFF_FRM. Hole has priority: gift discarded same frame.
// - PLAY: gift only -> gifts+1; gifts reaches GIFT_GOAL -> WON.
// - HIT: holes ignored, gifts committed as in PLAY (goal -> WON); cnt-1 per startOfFrame; at 0 -> PLAY.
// - IDLE/LOST/WON: no commits; start_game high -> lives=LIVES, gifts=0, score=0, flags cleared, -> PLAY next clk.
// - start_game ignored in PLAY/HIT. endgame=1 in LOST/WON; victory=1 in WON only.
// - Counters never wrap: lives floors at 0, gifts caps at GIFT_GOAL.
// - Reset mid-frame/mid-holdoff: full return to reset values, no pulse.
// CONFIGURATION
// - GAME_EVENT_SCORE_EN defined: score +10 per committed gift, +1 per frame in PLAY; saturates at 16'hFFFF.
// - Undefined: score tied 16'h0000, no score logic synthesised.
// TESTING
// - Reset, start_game=1 1clk -> state PLAY, lives=3, gifts=0, endgame=0.
// - 3 collision cycles (Obj=4'b0010) in one frame -> one SingleHitPulse; hit_mask=0010; cleared next SOF.
// - Hole collision in PLAY, then SOF -> lives 3->2, state HIT; 2nd hole in next 30 frames ignored; frame 31 -> PLAY.
// - Hole+gift same frame -> lives-1, gifts unchanged.
// - 5 gifts over 5 frames -> state WON, endgame=1, victory=1; score=50+PLAY-frames (macro) / 0 (no macro).
// - 3 holes (holdoffs expiring) -> lives=0, LOST, endgame=1, victory=0; start_game -> PLAY, lives=3.

Source files
------------

// File: rtl/game_event_ctrl.sv
// game_event_ctrl: merges the ball drawing request with NUM_OBJ object layers,
// tracks per-frame collision events (hit mask, single-hit pulse, tile gift/hole
// flags), and runs the game FSM (lives, gift goal, respawn holdoff, endgame).
// Optional build macro GAME_EVENT_SCORE_EN enables the saturating score counter;
// without it, score is tied to zero and no score logic exists.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for start_game
// PLAY  | game running; hole and gift events are committed at frame start
// HIT   | respawn holdoff; holes ignored, gifts still count
// LOST  | lives exhausted; endgame held until start_game
// WON   | gift goal reached; endgame and victory held until start_game
module game_event_ctrl #(
  parameter int NUM_OBJ     = 4,
  parameter int LIVES       = 3,
  parameter int GIFT_GOAL   = 5,
  parameter int HOLDOFF_FRM = 30
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic                             startOfFrame,
  input  logic                             start_game,
  input  logic                             drawing_request_Ball,
  input  logic [NUM_OBJ-1:0]               drawing_request_Obj,
  input  logic [1:0]                       TileType,
  output logic                             collision,
  output logic [NUM_OBJ-1:0]               hit_mask,
  output logic                             SingleHitPulse,
  output logic [$clog2(LIVES+1)-1:0]       lives,
  output logic [$clog2(GIFT_GOAL+1)-1:0]   gifts,
  output logic [15:0]                      score,
  output logic [2:0]                       game_state,
  output logic                             endgame,
  output logic                             victory
);

  localparam int LW = $clog2(LIVES + 1);
  localparam int GW = $clog2(GIFT_GOAL + 1);
  localparam int CW = (HOLDOFF_FRM < 1) ? 1 : $clog2(HOLDOFF_FRM + 1);

  localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
  localparam logic [GW-1:0] GOAL       = GW'(GIFT_GOAL);
  localparam logic [CW-1:0] HOLD_INIT  = CW'(HOLDOFF_FRM);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_LOST = 3'd3,
    S_WON  = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   holdoff_cnt;
  logic            hit_sem;
  logic            hole_seen;
  logic            gift_seen;

  logic            tile_hit;
  logic            hole_evt;
  logic            gift_evt;
  logic            start_ok;
  logic            gift_commit;
  logic [GW-1:0]   gifts_inc;
  logic [LW-1:0]   lives_dec;

  // Collision is the only combinational output: ball over any object layer.
  assign collision = drawing_request_Ball & (|drawing_request_Obj);

  // Tile events only count when the ball overlaps the tile layer (bit 0).
  assign tile_hit = collision & drawing_request_Obj[0];
  assign hole_evt = tile_hit & (TileType == 2'b11);
  assign gift_evt = tile_hit & (TileType == 2'b10);

  // start_game only acts while no game is in progress.
  assign start_ok = start_game &
                    ((state == S_IDLE) || (state == S_LOST) || (state == S_WON));

  // A gift is committed at frame start in HIT, or in PLAY when no hole
  // shares the same frame (hole wins). The goal cap keeps gifts from wrapping.
  assign gift_commit = startOfFrame & gift_seen & (gifts != GOAL) &
                       (((state == S_PLAY) & ~hole_seen) | (state == S_HIT));

  assign gifts_inc = gifts + GW'(1);
  assign lives_dec = (lives != '0) ? (lives - LW'(1)) : '0;

  assign game_state = state;

  // Per-frame collision bookkeeping: semaphore, one-shot pulse, sticky mask.
  // A collision in the startOfFrame cycle belongs to the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_sem        <= 1'b0;
      SingleHitPulse <= 1'b0;
      hit_mask       <= '0;
    end else begin
      SingleHitPulse <= collision & (startOfFrame | ~hit_sem);
      if (startOfFrame) begin
        hit_sem  <= collision;
        hit_mask <= collision ? drawing_request_Obj : '0;
      end else begin
        hit_sem  <= hit_sem | collision;
        if (collision)
          hit_mask <= hit_mask | drawing_request_Obj;
      end
    end
  end

  // Tile event flags accumulate over a frame and restart at each frame start;
  // the previous frame's flags are what the FSM commits in that same cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hole_seen <= 1'b0;
      gift_seen <= 1'b0;
    end else if (start_ok) begin
      hole_seen <= 1'b0;
      gift_seen <= 1'b0;
    end else if (startOfFrame) begin
      hole_seen <= hole_evt;
      gift_seen <= gift_evt;
    end else begin
      hole_seen <= hole_seen | hole_evt;
      gift_seen <= gift_seen | gift_evt;
    end
  end

  // Game FSM with registered lives, gifts, holdoff counter and end flags.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= S_IDLE;
      lives       <= LIVES_INIT;
      gifts       <= '0;
      holdoff_cnt <= '0;
      endgame     <= 1'b0;
      victory     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_LOST, S_WON: begin
          if (start_game) begin
            state       <= S_PLAY;
            lives       <= LIVES_INIT;
            gifts       <= '0;
            holdoff_cnt <= '0;
            endgame     <= 1'b0;
            victory     <= 1'b0;
          end
        end
        S_PLAY: begin
          if (startOfFrame) begin
            if (hole_seen) begin
              lives <= lives_dec;
              if (lives_dec == '0) begin
                state   <= S_LOST;
                endgame <= 1'b1;
              end else begin
                state       <= S_HIT;
                holdoff_cnt <= HOLD_INIT;
              end
            end else if (gift_commit) begin
              gifts <= gifts_inc;
              if (gifts_inc == GOAL) begin
                state   <= S_WON;
                endgame <= 1'b1;
                victory <= 1'b1;
              end
            end
          end
        end
        S_HIT: begin
          if (startOfFrame) begin
            if (gift_commit)
              gifts <= gifts_inc;
            if (gift_commit && (gifts_inc == GOAL)) begin
              state   <= S_WON;
              endgame <= 1'b1;
              victory <= 1'b1;
            end else if (holdoff_cnt <= CW'(1)) begin
              state       <= S_PLAY;
              holdoff_cnt <= '0;
            end else begin
              holdoff_cnt <= holdoff_cnt - CW'(1);
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          endgame <= 1'b0;
          victory <= 1'b0;
        end
      endcase
    end
  end

`ifdef GAME_EVENT_SCORE_EN
  logic [15:0] score_q;
  logic [4:0]  score_inc;
  logic [16:0] score_sum;

  assign score_inc = {4'd0, startOfFrame & (state == S_PLAY)} +
                     (gift_commit ? 5'd10 : 5'd0);
  assign score_sum = {1'b0, score_q} + {12'd0, score_inc};

  // Score: +1 per frame spent in PLAY, +10 per committed gift, saturating.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      score_q <= '0;
    else if (start_ok)
      score_q <= '0;
    else if (score_sum[16])
      score_q <= 16'hFFFF;
    else
      score_q <= score_sum[15:0];
  end

  assign score = score_q;
`else
  assign score = 16'h0000;
`endif

endmodule

// File: tb/tb_game_event_ctrl.sv
// Self-checking bench for game_event_ctrl (default parameters).
// Honours GAME_EVENT_SCORE_EN for the expected score.
module tb_game_event_ctrl;

  localparam int P_LIVES = 3;
  localparam int P_GOAL  = 5;
  localparam int P_HOLD  = 30;

  localparam int ST_IDLE = 0;
  localparam int ST_PLAY = 1;
  localparam int ST_HIT  = 2;
  localparam int ST_LOST = 3;
  localparam int ST_WON  = 4;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        start_game;
  logic        drawing_request_Ball;
  logic [3:0]  drawing_request_Obj;
  logic [1:0]  TileType;
  logic        collision;
  logic [3:0]  hit_mask;
  logic        SingleHitPulse;
  logic [1:0]  lives;
  logic [2:0]  gifts;
  logic [15:0] score;
  logic [2:0]  game_state;
  logic        endgame;
  logic        victory;

  game_event_ctrl dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (startOfFrame),
    .start_game           (start_game),
    .drawing_request_Ball (drawing_request_Ball),
    .drawing_request_Obj  (drawing_request_Obj),
    .TileType             (TileType),
    .collision            (collision),
    .hit_mask             (hit_mask),
    .SingleHitPulse       (SingleHitPulse),
    .lives                (lives),
    .gifts                (gifts),
    .score                (score),
    .game_state           (game_state),
    .endgame              (endgame),
    .victory              (victory)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int coll_seen;

  // Reference model: game described as integers and per-frame events.
  int m_state, m_lives, m_gifts, m_score, m_mask, m_pulse, m_cnt;
  bit m_frame_hit, m_hole, m_gift;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_score();
`ifdef GAME_EVENT_SCORE_EN
    return m_score;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_lives = P_LIVES; m_gifts = 0; m_score = 0;
    m_mask = 0; m_pulse = 0; m_cnt = 0;
    m_frame_hit = 0; m_hole = 0; m_gift = 0;
  endtask

  // Apply last frame's events at a frame boundary.
  task automatic commit_frame(input bit h, input bit g);
    int nxt;
    nxt = m_state;
    if (m_state == ST_PLAY) m_score += 1;
    if (m_state == ST_PLAY && h) begin
      if (m_lives > 0) m_lives -= 1;
      if (m_lives == 0) nxt = ST_LOST;
      else begin
        nxt = ST_HIT;
        m_cnt = P_HOLD;
      end
    end else begin
      if (g && m_gifts < P_GOAL) begin
        m_gifts += 1;
        m_score += 10;
      end
      if (m_gifts == P_GOAL) nxt = ST_WON;
      else if (m_state == ST_HIT) begin
        m_cnt -= 1;
        if (m_cnt <= 0) nxt = ST_PLAY;
      end
    end
    if (m_score > 65535) m_score = 65535;
    m_state = nxt;
  endtask

  task automatic model_clk(input bit sof, input bit st, input bit ball,
                           input logic [3:0] obj, input logic [1:0] tile);
    bit coll, evh, evg, started, old_h, old_g;
    coll    = ball && (obj != 4'd0);
    evh     = coll && obj[0] && (tile == 2'b11);
    evg     = coll && obj[0] && (tile == 2'b10);
    started = st && (m_state == ST_IDLE || m_state == ST_LOST || m_state == ST_WON);
    old_h   = m_hole;
    old_g   = m_gift;
    m_pulse = (coll && (sof || !m_frame_hit)) ? 1 : 0;
    if (sof) begin
      m_frame_hit = coll;
      m_mask      = coll ? int'(obj) : 0;
    end else begin
      m_frame_hit = m_frame_hit || coll;
      m_mask      = m_mask | (coll ? int'(obj) : 0);
    end
    if (started) begin
      m_hole = 0; m_gift = 0;
    end else if (sof) begin
      m_hole = evh; m_gift = evg;
    end else begin
      m_hole = m_hole || evh; m_gift = m_gift || evg;
    end
    if (started) begin
      m_state = ST_PLAY; m_lives = P_LIVES; m_gifts = 0; m_score = 0;
    end else if (sof && (m_state == ST_PLAY || m_state == ST_HIT)) begin
      commit_frame(old_h, old_g);
    end
  endtask

  task automatic check_all();
    chk("state",   int'(game_state),     m_state);
    chk("lives",   int'(lives),          m_lives);
    chk("gifts",   int'(gifts),          m_gifts);
    chk("mask",    int'(hit_mask),       m_mask);
    chk("pulse",   int'(SingleHitPulse), m_pulse);
    chk("endgame", int'(endgame),        (m_state == ST_LOST || m_state == ST_WON) ? 1 : 0);
    chk("victory", int'(victory),        (m_state == ST_WON) ? 1 : 0);
    chk("score",   int'(score),          exp_score());
  endtask

  // One clock: drive, check comb collision, clock, compare with model.
  task automatic step(input bit sof, input bit st, input bit ball,
                      input logic [3:0] obj, input logic [1:0] tile);
    startOfFrame = sof; start_game = st; drawing_request_Ball = ball;
    drawing_request_Obj = obj; TileType = tile;
    #1;
    coll_seen = int'(collision);
    chk("collision", coll_seen, (ball && obj != 4'd0) ? 1 : 0);
    @(posedge clk);
    model_clk(sof, st, ball, obj, tile);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    startOfFrame = 0; start_game = 0; drawing_request_Ball = 0;
    drawing_request_Obj = 4'd0; TileType = 2'b00;
    resetN = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    resetN = 1'b1;
  endtask

  // kind bit0: hole collision cycle, bit1: gift collision cycle; then frame start.
  task automatic frame_with(input int kind);
    if (kind[0]) step(0, 0, 1, 4'b0001, 2'b11);
    if (kind[1]) step(0, 0, 1, 4'b0001, 2'b10);
    step(0, 0, 0, 4'b0000, 2'b00);
    step(1, 0, 0, 4'b0000, 2'b00);
  endtask

  typedef struct {
    logic       sof;
    logic       st;
    logic       ball;
    logic [3:0] obj;
    logic [1:0] tile;
    int         e_state;
    int         e_lives;
    int         e_gifts;
    int         e_mask;
    int         e_pulse;
    int         e_coll;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int score_exp;
    // sof st ball obj tile | state lives gifts mask pulse coll
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 2'b00, ST_PLAY, 3, 0, 4'b0000, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'b0010, 2'b00, ST_PLAY, 3, 0, 4'b0010, 1, 1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'b0010, 2'b00, ST_PLAY, 3, 0, 4'b0010, 0, 1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'b0010, 2'b00, ST_PLAY, 3, 0, 4'b0010, 0, 1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, ST_PLAY, 3, 0, 4'b0010, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, ST_PLAY, 3, 0, 4'b0000, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'b0100, 2'b00, ST_PLAY, 3, 0, 4'b0100, 1, 1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'b1000, 2'b00, ST_PLAY, 3, 0, 4'b1000, 1, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'b0001, 2'b11, ST_PLAY, 3, 0, 4'b1001, 0, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, ST_HIT,  2, 0, 4'b0000, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 4'b0000, 2'b00, ST_HIT,  2, 0, 4'b0000, 0, 0};

    resetN = 1'b0;
    startOfFrame = 0; start_game = 0; drawing_request_Ball = 0;
    drawing_request_Obj = 4'd0; TileType = 2'b00;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_state", int'(game_state), ST_IDLE);
    chk("rst_lives", int'(lives), P_LIVES);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].sof, tbl[i].st, tbl[i].ball, tbl[i].obj, tbl[i].tile);
      chk($sformatf("tbl%0d_coll", i),  coll_seen,             tbl[i].e_coll);
      chk($sformatf("tbl%0d_state", i), int'(game_state),      tbl[i].e_state);
      chk($sformatf("tbl%0d_lives", i), int'(lives),           tbl[i].e_lives);
      chk($sformatf("tbl%0d_gifts", i), int'(gifts),           tbl[i].e_gifts);
      chk($sformatf("tbl%0d_mask", i),  int'(hit_mask),        tbl[i].e_mask);
      chk($sformatf("tbl%0d_pulse", i), int'(SingleHitPulse),  tbl[i].e_pulse);
    end

    // Holdoff: holes ignored for 30 frames, PLAY resumes at the 30th frame start.
    for (int k = 1; k <= P_HOLD; k++) begin
      frame_with(1);
      chk($sformatf("hold%0d_state", k), int'(game_state), (k < P_HOLD) ? ST_HIT : ST_PLAY);
      chk($sformatf("hold%0d_lives", k), int'(lives), 2);
    end
    frame_with(1);
    chk("hole2_lives", int'(lives), 1);
    chk("hole2_state", int'(game_state), ST_HIT);
    for (int k = 0; k < P_HOLD; k++) frame_with(0);
    chk("hold_exit_state", int'(game_state), ST_PLAY);

    // Third hole arrives together with a gift: hole wins, game lost.
    frame_with(3);
    chk("lost_lives",   int'(lives), 0);
    chk("lost_gifts",   int'(gifts), 0);
    chk("lost_state",   int'(game_state), ST_LOST);
    chk("lost_endgame", int'(endgame), 1);
    chk("lost_victory", int'(victory), 0);

    step(0, 1, 0, 4'b0000, 2'b00);
    chk("restart_state", int'(game_state), ST_PLAY);
    chk("restart_lives", int'(lives), P_LIVES);
    chk("restart_end",   int'(endgame), 0);

    // Five gift frames reach the goal.
    for (int k = 1; k <= P_GOAL; k++) begin
      frame_with(2);
      chk($sformatf("gift%0d_gifts", k), int'(gifts), k);
    end
    chk("won_state",   int'(game_state), ST_WON);
    chk("won_endgame", int'(endgame), 1);
    chk("won_victory", int'(victory), 1);
`ifdef GAME_EVENT_SCORE_EN
    score_exp = 55;
`else
    score_exp = 0;
`endif
    chk("won_score", int'(score), score_exp);
    frame_with(1);
    chk("won_hold_state", int'(game_state), ST_WON);
    chk("won_hold_lives", int'(lives), P_LIVES);

    // Reset in the middle of a holdoff with a fresh pulse in flight.
    step(0, 1, 0, 4'b0000, 2'b00);
    frame_with(1);
    chk("pre_rst_state", int'(game_state), ST_HIT);
    frame_with(0);
    step(0, 0, 1, 4'b0010, 2'b00);
    do_reset();
    chk("midrst_pulse", int'(SingleHitPulse), 0);
    chk("midrst_state", int'(game_state), ST_IDLE);

    // Randomized run against the model.
    step(0, 1, 0, 4'b0000, 2'b00);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0,
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             2'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
